// File: rtl/cpu_debug_scanner.sv
// cpu_debug_scanner
// Walks the CPU debug slots (GPRs, PC, instruction, watch address, watch
// data), captures each one and offers it to the display writer as a
// valid/ready transaction. After the last slot is accepted it idles for
// REFRESH_GAP cycles before starting the next frame.
//
// Ports:
//   clk, reset     free-running board clock, async active-high reset
//   rf_addr/rf_data   register-file debug read (combinational in the CPU)
//   mem_addr/mem_data memory-watch read (combinational in the CPU)
//   cpu_pc, cpu_inst  live CPU state
//   mem_addr_in, mem_addr_load  user update of the watch address
//   disp_valid/disp_ready/disp_slot/disp_value  slot transaction
//   frame_done     one-cycle pulse after the last slot is accepted
module cpu_debug_scanner #(
   parameter int unsigned NUM_RF      = 32,
   parameter int unsigned REFRESH_GAP = 50000,
   parameter int unsigned GAP_W       = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic [4:0]  rf_addr,
   input  logic [31:0] rf_data,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic [31:0] cpu_pc,
   input  logic [31:0] cpu_inst,
   input  logic [31:0] mem_addr_in,
   input  logic        mem_addr_load,
   output logic        disp_valid,
   input  logic        disp_ready,
   output logic [5:0]  disp_slot,
   output logic [31:0] disp_value,
   output logic        frame_done
);

   localparam int unsigned SLOT_W = 6;
   localparam int unsigned RF_W   = 5;
   localparam int unsigned DATA_W = 32;

   localparam logic [SLOT_W-1:0] SLOT_PC    = SLOT_W'(NUM_RF);
   localparam logic [SLOT_W-1:0] SLOT_INST  = SLOT_W'(NUM_RF + 1);
   localparam logic [SLOT_W-1:0] SLOT_MADDR = SLOT_W'(NUM_RF + 2);
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_RF + 3);

   typedef enum logic [1:0] {
      ST_GAP,
      ST_ADDR,
      ST_CAPT,
      ST_SEND
   } state_t;

   state_t              state_q, state_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [RF_W-1:0]     rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   value_q, value_d;
   logic                frame_done_q, frame_done_d;
   logic [DATA_W-1:0]   capt_src_c;

   // The two low address bits are dropped: watch reads are word aligned.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^mem_addr_in[1:0];

   // Source of the value latched in CAPT, chosen by the current slot.
   always_comb begin
      capt_src_c = rf_data;
      if (slot_q == SLOT_PC) begin
         capt_src_c = cpu_pc;
      end else if (slot_q == SLOT_INST) begin
         capt_src_c = cpu_inst;
      end else if (slot_q == SLOT_MADDR) begin
         capt_src_c = mem_addr_q;
      end else if (slot_q == SLOT_LAST) begin
         capt_src_c = mem_data;
      end
   end

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_GAP;
         gap_q        <= '0;
         slot_q       <= '0;
         rf_addr_q    <= '0;
         mem_addr_q   <= '0;
         valid_q      <= 1'b0;
         value_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         gap_q        <= gap_d;
         slot_q       <= slot_d;
         rf_addr_q    <= rf_addr_d;
         mem_addr_q   <= mem_addr_d;
         valid_q      <= valid_d;
         value_q      <= value_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      gap_d        = gap_q;
      slot_d       = slot_q;
      rf_addr_d    = rf_addr_q;
      valid_d      = valid_q;
      value_d      = value_q;
      frame_done_d = 1'b0;

      // Watch address updates in any state; CAPT of the same cycle still
      // sees the old register value.
      mem_addr_d = mem_addr_q;
      if (mem_addr_load) begin
         mem_addr_d = {mem_addr_in[31:2], 2'b00};
      end

      case (state_q)
         ST_GAP: begin
            if (gap_q == '0) begin
               slot_d  = '0;
               state_d = ST_ADDR;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end

         // rf_addr is registered here so the read settles for all of CAPT.
         ST_ADDR: begin
            if (slot_q < SLOT_PC) begin
               rf_addr_d = slot_q[RF_W-1:0];
            end
            state_d = ST_CAPT;
         end

         ST_CAPT: begin
            value_d = capt_src_c;
            valid_d = 1'b1;
            state_d = ST_SEND;
         end

         ST_SEND: begin
            if (valid_q && disp_ready) begin
               valid_d = 1'b0;
               if (slot_q == SLOT_LAST) begin
                  frame_done_d = 1'b1;
                  gap_d        = GAP_W'(REFRESH_GAP);
                  slot_d       = '0;
                  state_d      = ST_GAP;
               end else begin
                  slot_d  = slot_q + SLOT_W'(1);
                  state_d = ST_ADDR;
               end
            end
         end

         default: begin
            state_d = ST_GAP;
         end
      endcase
   end

   assign rf_addr    = rf_addr_q;
   assign mem_addr   = mem_addr_q;
   assign disp_valid = valid_q;
   assign disp_slot  = slot_q;
   assign disp_value = value_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/cpu_debug_scanner.md
Name: cpu_debug_scanner

Overview:
- Sequential scan engine downstream of the single-cycle CPU's debug taps and upstream of the board display driver.
- Walks every debug slot in order: 32 GPRs, PC, instruction, memory-watch address and memory-watch data.
- Drives rf_addr and mem_addr into the CPU and captures the returned data.
- Presents each slot as a valid/ready transaction to the display writer, then waits a programmable refresh gap before starting the next frame.

Parameters:
- NUM_RF, 32, number of GPR slots scanned (slots 0..NUM_RF-1).
- REFRESH_GAP, 50000, idle clk cycles between end of one frame and start of the next; 0 means back-to-back frames.
- GAP_W, 16, width of the refresh counter; must hold REFRESH_GAP.

Ports:
- clk  in  1  system clock (free-running board clock, not the gated cpu_clk).
- reset  in  1  asynchronous, active-high reset.
- rf_addr  out  5  register-file debug read address to the CPU.
- rf_data  in  32  register-file debug read data (combinational from rf_addr).
- mem_addr  out  32  memory-watch address to the CPU.
- mem_data  in  32  memory-watch data (combinational from mem_addr).
- cpu_pc  in  32  current CPU PC.
- cpu_inst  in  32  current CPU instruction.
- mem_addr_in  in  32  new watch address from the user input path.
- mem_addr_load  in  1  one-cycle strobe that loads mem_addr_in.
- disp_valid  out  1  slot transaction valid.
- disp_ready  in  1  display writer accepts.
- disp_slot  out  6  slot index: 0..31 GPR, 32 PC, 33 INST, 34 MADDR, 35 MDATA.
- disp_value  out  32  captured slot value.
- frame_done  out  1  one-cycle pulse when slot 35 is accepted.

Behaviour:
- Reset (async assert, sync release) sets every output and register to 0:
  - rf_addr=0, mem_addr=0, disp_valid=0, disp_slot=0, disp_value=0, frame_done=0.
  - state=GAP, gap counter=0, so the first frame starts on the first clk after reset deasserts.
- Reset asserted mid-frame aborts the frame immediately. No partial transaction is held, and disp_valid drops asynchronously.
- FSM states are GAP, ADDR, CAPT, SEND.
  - GAP: if counter==0, go to ADDR with slot=0. Otherwise decrement the counter.
  - ADDR: drive rf_addr=slot[4:0] when slot<32; rf_addr holds its last value otherwise. Always go to CAPT next cycle, giving one full cycle of settle time for combinational reads.
  - CAPT: latch disp_value from the source selected by slot: rf_data, cpu_pc, cpu_inst, mem_addr register, or mem_data. Set disp_valid=1 and go to SEND.
  - SEND: hold disp_valid, disp_slot and disp_value stable until disp_valid&&disp_ready. On acceptance, disp_valid=0.
    - If slot<35: slot+1, go to ADDR.
    - If slot==35: pulse frame_done, load counter=REFRESH_GAP, go to GAP.
- Per-slot latency is 3 cycles minimum (ADDR, CAPT, SEND with ready high). A full frame with ready tied high is 36*3=108 cycles.
- disp_slot equals the internal slot and changes only when a transaction is accepted; it never changes while disp_valid=1.
- The mem_addr register loads {mem_addr_in[31:2],2'b00} on mem_addr_load. Writes are word-aligned, and the load is accepted in any state.
  - A load during the same frame is reflected in MADDR/MDATA only if it occurs before that slot's CAPT cycle.
  - A load in the same cycle as CAPT of slot 34 or 35: CAPT samples the old value, and the new value is visible from the next cycle.
- mem_data is sampled in CAPT of slot 35 using the mem_addr value driven at that time. If mem_addr changed in the preceding ADDR cycle, this is still valid because the read is combinational and has settled.
- disp_ready is ignored when disp_valid=0, and ready high in GAP has no effect.
- The scanner never stalls the CPU. Captured values reflect whatever CPU state exists at the CAPT cycle, and frames are not required to be atomic snapshots.

Test Plan:
- Reset with rf_data=addr*4, ready tied 1, REFRESH_GAP=0 -> slots 0..31 emit values 0,4,...,124. Slot 32 = cpu_pc (0x00000010), slot 33 = cpu_inst. frame_done pulses at cycle 108 after release, and the next frame starts immediately.
- Backpressure: ready=0 for 10 cycles on slot 5 -> disp_valid, disp_slot=5 and disp_value=20 are held stable all 10 cycles. Slot 6 appears 2 cycles after acceptance.
- mem_addr_load with 0x0000_0107 during GAP -> mem_addr=0x0000_0104. Slot 34 value = 0x104, and slot 35 = mem_data for 0x104.
- Load 0x20 exactly in the CAPT cycle of slot 34 (old 0x0) -> slot 34 reports 0x0. mem_addr=0x20 the next cycle, and slot 35 reports mem_data for 0x20.
- REFRESH_GAP=5 -> exactly 5 GAP cycles plus 1 transition cycle between the frame_done pulse and ADDR of slot 0. No disp_valid in between.
- Assert reset while disp_valid=1 on slot 17 -> disp_valid drops in the same cycle and all outputs go to 0. After release, the scan restarts at slot 0.
